// File: rtl/ex_mem_stage_if.sv
// EX/MEM stage bus: EX-side inputs, the registered MEM-side outputs and the
// redirect/flush signals back to the front end.
interface ex_mem_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
);

  logic                      Stall;
  logic                      Valid_in;
  logic [DATA_WIDTH-1:0]     ALUResult_in;
  logic                      Zero_in;
  logic [DATA_WIDTH-1:0]     PCPlus4_in;
  logic [DATA_WIDTH-1:0]     SignExtImm_in;
  logic [DATA_WIDTH-1:0]     RtData_in;
  logic [REG_ADDR_WIDTH-1:0] WriteReg_in;
  logic                      RegWrite_in;
  logic                      MemRead_in;
  logic                      MemWrite_in;
  logic                      MemToReg_in;
  logic                      Branch_in;
  logic                      Jump_in;
  logic                      JumpReg_in;

  logic                      Valid_out;
  logic [DATA_WIDTH-1:0]     ALUResult_out;
  logic [DATA_WIDTH-1:0]     RtData_out;
  logic [REG_ADDR_WIDTH-1:0] WriteReg_out;
  logic                      RegWrite_out;
  logic                      MemRead_out;
  logic                      MemWrite_out;
  logic                      MemToReg_out;
  logic                      BranchTaken;
  logic [DATA_WIDTH-1:0]     PCTarget;
  logic                      FlushOut;
  logic [CNT_WIDTH-1:0]      RetiredCount;
  logic [CNT_WIDTH-1:0]      TakenCount;

  // The pipeline stage itself.
  modport slave (
    input  Stall, Valid_in, ALUResult_in, Zero_in, PCPlus4_in, SignExtImm_in,
           RtData_in, WriteReg_in, RegWrite_in, MemRead_in, MemWrite_in,
           MemToReg_in, Branch_in, Jump_in, JumpReg_in,
    output Valid_out, ALUResult_out, RtData_out, WriteReg_out, RegWrite_out,
           MemRead_out, MemWrite_out, MemToReg_out, BranchTaken, PCTarget,
           FlushOut, RetiredCount, TakenCount
  );

  // The surrounding pipeline (EX stage, MEM stage, fetch redirect).
  modport master (
    output Stall, Valid_in, ALUResult_in, Zero_in, PCPlus4_in, SignExtImm_in,
           RtData_in, WriteReg_in, RegWrite_in, MemRead_in, MemWrite_in,
           MemToReg_in, Branch_in, Jump_in, JumpReg_in,
    input  Valid_out, ALUResult_out, RtData_out, WriteReg_out, RegWrite_out,
           MemRead_out, MemWrite_out, MemToReg_out, BranchTaken, PCTarget,
           FlushOut, RetiredCount, TakenCount
  );

endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch/jump resolution, registered PC
// redirect, one-cycle front-end flush and debug performance counters.
//
// A taken instruction raises BranchTaken for one capture cycle. While it is
// high, the instruction arriving from EX is the one fetched down the wrong
// path, so it is converted to a bubble here (its controls are cleared and it
// cannot itself redirect). Stall freezes everything, including that pending
// squash, so the squash lands on the first non-stalled capture.
module ex_mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic           Clk,
  input  logic           Reset,
  ex_mem_stage_if.slave  bus
);

  logic                      valid_q;
  logic [DATA_WIDTH-1:0]     alu_result_q;
  logic [DATA_WIDTH-1:0]     rt_data_q;
  logic [REG_ADDR_WIDTH-1:0] write_reg_q;
  logic                      reg_write_q;
  logic                      mem_read_q;
  logic                      mem_write_q;
  logic                      mem_to_reg_q;
  logic                      taken_q;
  logic [DATA_WIDTH-1:0]     target_q;
  logic [CNT_WIDTH-1:0]      retired_q;
  logic [CNT_WIDTH-1:0]      taken_cnt_q;

  logic                      squash;
  logic                      eff_valid;
  logic                      is_jump;
  logic                      take;
  logic [DATA_WIDTH-1:0]     branch_target;
  logic [DATA_WIDTH-1:0]     next_target;

  // Resolve slot validity, the redirect decision and the candidate target.
  always_comb begin
    squash        = taken_q;
    eff_valid     = bus.Valid_in & ~squash;
    is_jump       = bus.Jump_in | bus.JumpReg_in;
    take          = eff_valid & ((bus.Branch_in & bus.Zero_in) | is_jump);
    // Word offset scaled to bytes; the sum wraps silently at the top of memory.
    branch_target = bus.PCPlus4_in + (bus.SignExtImm_in << 2);
    // Jumps carry their absolute target on the ALU result and beat a branch.
    next_target   = is_jump ? bus.ALUResult_in : branch_target;
  end

  // Pipeline register: reset clears all, stall holds all, otherwise capture.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q      <= 1'b0;
      alu_result_q <= '0;
      rt_data_q    <= '0;
      write_reg_q  <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (!bus.Stall) begin
      valid_q      <= eff_valid;
      alu_result_q <= bus.ALUResult_in;
      rt_data_q    <= bus.RtData_in;
      write_reg_q  <= bus.WriteReg_in;
      // Bubbles and squashed slots must never write the register file or memory.
      reg_write_q  <= bus.RegWrite_in & eff_valid;
      mem_read_q   <= bus.MemRead_in  & eff_valid;
      mem_write_q  <= bus.MemWrite_in & eff_valid;
      mem_to_reg_q <= bus.MemToReg_in & eff_valid;
    end
  end

  // Redirect state: taken flag each capture, target only when a redirect happens.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      taken_q  <= 1'b0;
      target_q <= '0;
    end else if (!bus.Stall) begin
      taken_q <= take;
      if (take) begin
        target_q <= next_target;
      end
    end
  end

  // Debug counters; both wrap naturally at all-ones.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      retired_q   <= '0;
      taken_cnt_q <= '0;
    end else if (!bus.Stall) begin
      if (eff_valid) begin
        retired_q <= retired_q + CNT_WIDTH'(1);
      end
      if (take) begin
        taken_cnt_q <= taken_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.Valid_out     = valid_q;
  assign bus.ALUResult_out = alu_result_q;
  assign bus.RtData_out    = rt_data_q;
  assign bus.WriteReg_out  = write_reg_q;
  assign bus.RegWrite_out  = reg_write_q;
  assign bus.MemRead_out   = mem_read_q;
  assign bus.MemWrite_out  = mem_write_q;
  assign bus.MemToReg_out  = mem_to_reg_q;
  assign bus.BranchTaken   = taken_q;
  assign bus.PCTarget      = target_q;
  assign bus.FlushOut      = taken_q;
  assign bus.RetiredCount  = retired_q;
  assign bus.TakenCount    = taken_cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: a vector table driven through a scoreboard queue on
// a full-width instance, plus hand sequences on a narrow-counter instance to
// reach the counter wrap.
module tb_ex_mem_stage;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ex_mem_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) b1 ();
  ex_mem_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4))  b2 ();

  ex_mem_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (b1)
  );

  ex_mem_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut_small (
    .Clk   (clk),
    .Reset (rst2),
    .bus   (b2)
  );

  // ctl = {RegWrite, MemRead, MemWrite, MemToReg}; bj = {Branch, Jump, JumpReg}
  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        vin;
    logic        zero;
    logic [3:0]  ctl;
    logic [2:0]  bj;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [31:0] rt;
    logic [4:0]  wr;
    logic        e_valid;
    logic [3:0]  e_ctl;
    logic        e_bt;
    logic [31:0] e_alu;
    logic [31:0] e_rt;
    logic [4:0]  e_wr;
    logic [31:0] e_tgt;
    logic [31:0] e_ret;
    logic [31:0] e_tkn;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];
  vec_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive1(input vec_t v);
    rst              = v.rst;
    b1.Stall         = v.stall;
    b1.Valid_in      = v.vin;
    b1.Zero_in       = v.zero;
    b1.RegWrite_in   = v.ctl[3];
    b1.MemRead_in    = v.ctl[2];
    b1.MemWrite_in   = v.ctl[1];
    b1.MemToReg_in   = v.ctl[0];
    b1.Branch_in     = v.bj[2];
    b1.Jump_in       = v.bj[1];
    b1.JumpReg_in    = v.bj[0];
    b1.ALUResult_in  = v.alu;
    b1.PCPlus4_in    = v.pc4;
    b1.SignExtImm_in = v.imm;
    b1.RtData_in     = v.rt;
    b1.WriteReg_in   = v.wr;
  endtask

  task automatic small_cycle(input logic r, input logic vin, input logic jmp);
    @(negedge clk);
    rst2         = r;
    b2.Valid_in  = vin;
    b2.Jump_in   = jmp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t exp_v;
    logic [3:0] act_ctl;

    //         rst   stall vin   zero  ctl      bj      alu           pc4           imm           rt           wr      ev    ectl     ebt   ealu          ert          ewr     etgt          eret   etkn
    vt[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, 3'b000, 32'h11,       32'h0,        32'h0,        32'h22,      5'd3,   1'b0, 4'b0000, 1'b0, 32'h0,        32'h0,       5'd0,   32'h0,        32'd0, 32'd0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, 3'b000, 32'h11,       32'h0,        32'h0,        32'h22,      5'd3,   1'b0, 4'b0000, 1'b0, 32'h0,        32'h0,       5'd0,   32'h0,        32'd0, 32'd0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b1000, 3'b000, 32'h11,       32'h0,        32'h0,        32'h22,      5'd3,   1'b1, 4'b1000, 1'b0, 32'h11,       32'h22,      5'd3,   32'h0,        32'd1, 32'd0};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 3'b100, 32'h0,        32'h00400010, 32'hFFFFFFFC, 32'h5,       5'd0,   1'b1, 4'b0000, 1'b1, 32'h0,        32'h5,       5'd0,   32'h00400000, 32'd2, 32'd1};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 3'b000, 32'h100,      32'h0,        32'h0,        32'hABCD,    5'd7,   1'b0, 4'b0000, 1'b0, 32'h100,      32'hABCD,    5'd7,   32'h00400000, 32'd2, 32'd1};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 3'b100, 32'h5,        32'h00400020, 32'h8,        32'h1,       5'd0,   1'b1, 4'b0000, 1'b0, 32'h5,        32'h1,       5'd0,   32'h00400000, 32'd3, 32'd1};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b1101, 3'b000, 32'h1000,     32'h0,        32'h0,        32'h0,       5'd9,   1'b1, 4'b1101, 1'b0, 32'h1000,     32'h0,       5'd9,   32'h00400000, 32'd4, 32'd1};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 3'b010, 32'hDEAD,     32'h0,        32'h0,        32'h33,      5'd1,   1'b0, 4'b0000, 1'b0, 32'hDEAD,     32'h33,      5'd1,   32'h00400000, 32'd4, 32'd1};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 3'b001, 32'h0040002C, 32'h0,        32'h0,        32'h0,       5'd31,  1'b1, 4'b0000, 1'b1, 32'h0040002C, 32'h0,       5'd31,  32'h0040002C, 32'd5, 32'd2};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 3'b100, 32'h77,       32'h100,      32'h4,        32'h2,       5'd2,   1'b0, 4'b0000, 1'b0, 32'h77,       32'h2,       5'd2,   32'h0040002C, 32'd5, 32'd2};
    vt[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 3'b110, 32'h00400080, 32'h200,      32'h1,        32'h3,       5'd0,   1'b1, 4'b0000, 1'b1, 32'h00400080, 32'h3,       5'd0,   32'h00400080, 32'd6, 32'd3};
    vt[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 3'b000, 32'h999,      32'h0,        32'h0,        32'h99,      5'd5,   1'b1, 4'b0000, 1'b1, 32'h00400080, 32'h3,       5'd0,   32'h00400080, 32'd6, 32'd3};
    vt[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 3'b010, 32'h999,      32'h0,        32'h0,        32'h99,      5'd5,   1'b1, 4'b0000, 1'b1, 32'h00400080, 32'h3,       5'd0,   32'h00400080, 32'd6, 32'd3};
    vt[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 3'b000, 32'h999,      32'h0,        32'h0,        32'h99,      5'd5,   1'b1, 4'b0000, 1'b1, 32'h00400080, 32'h3,       5'd0,   32'h00400080, 32'd6, 32'd3};
    vt[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 3'b000, 32'h500,      32'h0,        32'h0,        32'h44,      5'd4,   1'b0, 4'b0000, 1'b0, 32'h500,      32'h44,      5'd4,   32'h00400080, 32'd6, 32'd3};
    vt[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 3'b100, 32'h0,        32'hFFFFFFFC, 32'h1,        32'h0,       5'd0,   1'b1, 4'b0000, 1'b1, 32'h0,        32'h0,       5'd0,   32'h00000000, 32'd7, 32'd4};
    vt[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 3'b000, 32'h55,       32'h0,        32'h0,        32'h66,      5'd6,   1'b0, 4'b0000, 1'b0, 32'h0,        32'h0,       5'd0,   32'h0,        32'd0, 32'd0};
    vt[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b1000, 3'b010, 32'h1234,     32'h0,        32'h0,        32'h6,       5'd6,   1'b1, 4'b1000, 1'b1, 32'h1234,     32'h6,       5'd6,   32'h1234,     32'd1, 32'd1};
    vt[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 3'b000, 32'h8,        32'h0,        32'h0,        32'h7,       5'd8,   1'b0, 4'b0000, 1'b0, 32'h8,        32'h7,       5'd8,   32'h1234,     32'd1, 32'd1};

    b2.Stall         = 1'b0;
    b2.Valid_in      = 1'b0;
    b2.Zero_in       = 1'b0;
    b2.RegWrite_in   = 1'b0;
    b2.MemRead_in    = 1'b0;
    b2.MemWrite_in   = 1'b0;
    b2.MemToReg_in   = 1'b0;
    b2.Branch_in     = 1'b0;
    b2.Jump_in       = 1'b0;
    b2.JumpReg_in    = 1'b0;
    b2.ALUResult_in  = 32'h0;
    b2.PCPlus4_in    = 32'h0;
    b2.SignExtImm_in = 32'h0;
    b2.RtData_in     = 32'h0;
    b2.WriteReg_in   = 5'd0;
    drive1(vt[0]);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive1(vt[i]);
      sb.push_back(vt[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL row%0d scoreboard: got no expected entry, required one", i);
      end else begin
        exp_v   = sb.pop_front();
        act_ctl = {b1.RegWrite_out, b1.MemRead_out, b1.MemWrite_out, b1.MemToReg_out};
        chk($sformatf("row%0d valid", i), 32'(b1.Valid_out),     32'(exp_v.e_valid));
        chk($sformatf("row%0d ctl",   i), 32'(act_ctl),          32'(exp_v.e_ctl));
        chk($sformatf("row%0d taken", i), 32'(b1.BranchTaken),   32'(exp_v.e_bt));
        chk($sformatf("row%0d flush", i), 32'(b1.FlushOut),      32'(exp_v.e_bt));
        chk($sformatf("row%0d alu",   i), b1.ALUResult_out,      exp_v.e_alu);
        chk($sformatf("row%0d rt",    i), b1.RtData_out,         exp_v.e_rt);
        chk($sformatf("row%0d wr",    i), 32'(b1.WriteReg_out),  32'(exp_v.e_wr));
        chk($sformatf("row%0d target",i), b1.PCTarget,           exp_v.e_tgt);
        chk($sformatf("row%0d retired",i), b1.RetiredCount,      exp_v.e_ret);
        chk($sformatf("row%0d takencnt",i), b1.TakenCount,       exp_v.e_tkn);
      end
    end

    // Narrow counters: plain retire wrap after 16 valid captures.
    small_cycle(1'b1, 1'b0, 1'b0);
    chk("small reset retired", 32'(b2.RetiredCount), 32'd0);
    for (int n = 1; n <= 16; n++) begin
      small_cycle(1'b0, 1'b1, 1'b0);
      if (n == 15) chk("small retired at 15", 32'(b2.RetiredCount), 32'd15);
      if (n == 16) chk("small retired wrap",  32'(b2.RetiredCount), 32'd0);
    end

    // Back-to-back jumps: every other one is squashed, so 31 captures give 16 takes.
    small_cycle(1'b1, 1'b0, 1'b0);
    for (int n = 1; n <= 32; n++) begin
      small_cycle(1'b0, 1'b1, 1'b1);
      if (n == 1)  chk("small first jump taken", 32'(b2.BranchTaken), 32'd1);
      if (n == 2)  chk("small second jump squashed", 32'(b2.Valid_out), 32'd0);
      if (n == 29) begin
        chk("small taken at 29",   32'(b2.TakenCount),   32'd15);
        chk("small retired at 29", 32'(b2.RetiredCount), 32'd15);
      end
      if (n == 30) chk("small taken hold at 30", 32'(b2.TakenCount), 32'd15);
      if (n == 31) begin
        chk("small taken wrap",   32'(b2.TakenCount),   32'd0);
        chk("small retired wrap2", 32'(b2.RetiredCount), 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
